branch_resolve_ctrl: RTL and testbench

//  Sequences branch resolution in EX around the branch comparator.
//  - Drives the comparator's unsigned-select from funct3 and evaluates taken/not-taken from its less/equal flags.
//  - Predicts IF-stage branches from a 2-bit BHT and updates the BHT on resolution.
//  - On mispredict, issues a registered redirect/flush, then masks wrong-path EX slots for a fixed drain window.

---
 rtl/brc_pkg.sv | 37 +++
 rtl/branch_resolve_ctrl_bht.sv | 43 ++++
 rtl/branch_resolve_ctrl.sv | 166 ++++++++++++++++
 tb/tb_branch_resolve_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/brc_pkg.sv
// Shared types and constants for branch resolution control.
// Holds funct3 encodings, FSM states and 2-bit BHT counter helpers.
package brc_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_REDIRECT,
        ST_DRAIN
    } brc_state_e;

    typedef logic [1:0] bht_ctr_t;

    localparam bht_ctr_t BHT_INIT = 2'b01;

    // Saturating 2-bit counter step toward the resolved direction.
    function automatic bht_ctr_t bht_next(
        input bht_ctr_t c,
        input logic     taken
    );
        bht_ctr_t n;
        n = c;
        if (taken && (c != 2'b11)) begin
            n = c + 2'd1;
        end else if (!taken && (c != 2'b00)) begin
            n = c - 2'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/branch_resolve_ctrl_bht.sv
// 2-bit branch history table.
// Combinational read port, synchronous saturating-update write port.
module bht_2bit
    import brc_pkg::*;
#(
    parameter int ENTRIES = 64,
    localparam int IW     = $clog2(ENTRIES)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic [IW-1:0] i_rd_idx,
    output bht_ctr_t      o_rd_ctr,
    input  logic          i_wr_en,
    input  logic [IW-1:0] i_wr_idx,
    input  logic          i_wr_taken
);

    bht_ctr_t mem_q [ENTRIES];
    bht_ctr_t mem_d [ENTRIES];

    // Next table contents: one entry steps on a resolved branch.
    always_comb begin
        mem_d = mem_q;
        if (i_wr_en) begin
            mem_d[i_wr_idx] = bht_next(mem_q[i_wr_idx], i_wr_taken);
        end
    end

    // Table storage; reset reloads every entry with weak not-taken.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                mem_q[i] <= BHT_INIT;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Read sees the pre-update value when indices collide.
    assign o_rd_ctr = mem_q[i_rd_idx];

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Branch resolution sequencer: evaluates EX branches, predicts IF, redirects.
// Optional counters enabled by defining BRC_STATS_EN.
module branch_resolve_ctrl
    import brc_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int BHT_ENTRIES  = 64,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_stall,
    input  logic [XLEN-1:0] i_if_pc,
    output logic            o_pred_taken,
    input  logic            i_ex_valid,
    input  logic            i_ex_is_branch,
    input  logic [2:0]      i_ex_funct3,
    input  logic [XLEN-1:0] i_ex_pc,
    input  logic [XLEN-1:0] i_ex_target,
    input  logic            i_ex_pred_taken,
    output logic            o_br_un,
    input  logic            i_br_less,
    input  logic            i_br_equal,
    output logic            o_redirect_valid,
    output logic [XLEN-1:0] o_redirect_pc,
    output logic            o_flush,
    output logic [31:0]     o_stat_branches,
    output logic [31:0]     o_stat_mispredicts
);

    localparam int         IW       = $clog2(BHT_ENTRIES);
    localparam logic [2:0] CNT_INIT = 3'(DRAIN_CYCLES - 1);

    brc_state_e      state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] rpc_q, rpc_d;

    logic            legal;
    logic            taken;
    logic            res;
    logic            upd;
    logic            mispredict;
    logic [XLEN-1:0] fix_pc;
    bht_ctr_t        rd_ctr;
    logic            unused_if_pc;

    assign o_br_un = i_ex_funct3[1];

    // Branch outcome from comparator flags and the correct-path PC.
    always_comb begin
        legal = 1'b1;
        taken = 1'b0;
        case (i_ex_funct3)
            F3_BEQ:  taken = i_br_equal;
            F3_BNE:  taken = ~i_br_equal;
            F3_BLT:  taken = i_br_less;
            F3_BLTU: taken = i_br_less;
            F3_BGE:  taken = ~i_br_less;
            F3_BGEU: taken = ~i_br_less;
            default: legal = 1'b0;
        endcase
        res        = i_ex_valid & i_ex_is_branch
                   & (state_q == ST_RUN) & ~i_stall;
        upd        = res & legal;
        mispredict = upd & (taken != i_ex_pred_taken);
        fix_pc     = taken ? i_ex_target : i_ex_pc + XLEN'(4);
    end

    bht_2bit #(
        .ENTRIES (BHT_ENTRIES)
    ) u_bht (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_rd_idx   (i_if_pc[IW+1:2]),
        .o_rd_ctr   (rd_ctr),
        .i_wr_en    (upd),
        .i_wr_idx   (i_ex_pc[IW+1:2]),
        .i_wr_taken (taken)
    );

    assign o_pred_taken = rd_ctr[1];
    assign unused_if_pc = ^{i_if_pc[XLEN-1:IW+2], i_if_pc[1:0], rd_ctr[0]};

    // FSM state, drain counter and captured redirect target.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            rpc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rpc_q   <= rpc_d;
        end
    end

    // Next state: redirect for one unstalled cycle, then drain.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rpc_d   = rpc_q;
        unique case (state_q)
            ST_RUN: begin
                if (mispredict) begin
                    state_d = ST_REDIRECT;
                    rpc_d   = fix_pc;
                end
            end
            ST_REDIRECT: begin
                if (!i_stall) begin
                    state_d = ST_DRAIN;
                    cnt_d   = CNT_INIT;
                end
            end
            ST_DRAIN: begin
                if (!i_stall) begin
                    if (cnt_q == 3'd0) begin
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // Redirect and flush are asserted for the whole REDIRECT state.
    always_comb begin
        o_redirect_valid = (state_q == ST_REDIRECT);
        o_flush          = (state_q == ST_REDIRECT);
        o_redirect_pc    = o_redirect_valid ? rpc_q : '0;
    end

`ifdef BRC_STATS_EN
    logic [31:0] nbr_q, nbr_d;
    logic [31:0] nmis_q, nmis_d;

    // Counters step only on resolved legal branches, so stalls hold them.
    always_comb begin
        nbr_d  = nbr_q + 32'(upd);
        nmis_d = nmis_q + 32'(mispredict);
    end

    // Statistics registers, wrapping at 2^32.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            nbr_q  <= '0;
            nmis_q <= '0;
        end else begin
            nbr_q  <= nbr_d;
            nmis_q <= nmis_d;
        end
    end

    assign o_stat_branches    = nbr_q;
    assign o_stat_mispredicts = nmis_q;
`else
    assign o_stat_branches    = '0;
    assign o_stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl.
// Vector table plus hand sequences for drain, stall, saturation and reset.
module tb_branch_resolve_ctrl;

    localparam int XLEN  = 32;
    localparam int ENT   = 64;
    localparam int DRAIN = 2;
    localparam int NV    = 11;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic        ex_valid;
    logic        ex_is_branch;
    logic [2:0]  ex_f3;
    logic [31:0] ex_pc;
    logic [31:0] ex_tgt;
    logic        ex_pred;
    logic        br_un;
    logic        br_less;
    logic        br_equal;
    logic        red_valid;
    logic [31:0] red_pc;
    logic        flush;
    logic [31:0] stat_br;
    logic [31:0] stat_mis;

    always #5 clk = ~clk;

    branch_resolve_ctrl #(
        .XLEN         (XLEN),
        .BHT_ENTRIES  (ENT),
        .DRAIN_CYCLES (DRAIN)
    ) dut (
        .i_clk              (clk),
        .i_reset            (reset_n),
        .i_stall            (stall),
        .i_if_pc            (if_pc),
        .o_pred_taken       (pred_taken),
        .i_ex_valid         (ex_valid),
        .i_ex_is_branch     (ex_is_branch),
        .i_ex_funct3        (ex_f3),
        .i_ex_pc            (ex_pc),
        .i_ex_target        (ex_tgt),
        .i_ex_pred_taken    (ex_pred),
        .o_br_un            (br_un),
        .i_br_less          (br_less),
        .i_br_equal         (br_equal),
        .o_redirect_valid   (red_valid),
        .o_redirect_pc      (red_pc),
        .o_flush            (flush),
        .o_stat_branches    (stat_br),
        .o_stat_mispredicts (stat_mis)
    );

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        less;
        logic        eq;
        logic        pred;
        logic        e_un;
        logic        e_red;
        logic [31:0] e_pc;
    } vec_t;

    typedef struct {
        logic        v;
        logic [31:0] pc;
    } exp_t;

    vec_t        vt [NV];
    exp_t        sb [$];
    logic [1:0]  mbht [ENT];
    int          m_br;
    int          m_mis;
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int idx(input logic [31:0] pc);
        return int'(pc[7:2]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENT; i++) mbht[i] = 2'b01;
        m_br  = 0;
        m_mis = 0;
    endtask

    // Reference outcome for a branch that resolves in RUN.
    task automatic model_res(input logic [2:0] f3, input logic [31:0] pc,
                             input logic lt, input logic eq,
                             input logic pr);
        logic t;
        logic ok;
        int   k;
        ok = 1'b1;
        t  = 1'b0;
        case (f3)
            3'b000:         t = eq;
            3'b001:         t = !eq;
            3'b100, 3'b110: t = lt;
            3'b101, 3'b111: t = !lt;
            default:        ok = 1'b0;
        endcase
        if (ok) begin
            k = idx(pc);
            m_br++;
            if (t != pr) m_mis++;
            if (t && mbht[k] != 2'b11) mbht[k] = mbht[k] + 2'd1;
            else if (!t && mbht[k] != 2'b00) mbht[k] = mbht[k] - 2'd1;
        end
    endtask

    task automatic set_ex(input logic v, input logic [2:0] f3,
                          input logic [31:0] pc, input logic [31:0] tgt,
                          input logic lt, input logic eq, input logic pr);
        ex_valid     = v;
        ex_is_branch = 1'b1;
        ex_f3        = f3;
        ex_pc        = pc;
        ex_tgt       = tgt;
        br_less      = lt;
        br_equal     = eq;
        ex_pred      = pr;
    endtask

    task automatic chk_pred(input string nm, input logic [31:0] pc);
        if_pc = pc;
        #1;
        check(nm, 32'(pred_taken), 32'(mbht[idx(pc)][1]));
    endtask

    task automatic chk_stats(input string nm);
`ifdef BRC_STATS_EN
        check({nm, "_br"}, stat_br, m_br);
        check({nm, "_mis"}, stat_mis, m_mis);
`else
        check({nm, "_br"}, stat_br, 32'd0);
        check({nm, "_mis"}, stat_mis, 32'd0);
`endif
    endtask

    initial begin
        exp_t e;

        vt[0]  = '{3'b000, 32'h40, 32'h80, 0, 1, 0, 0, 1, 32'h80};
        vt[1]  = '{3'b110, 32'hFFFFFFFC, 32'h1000, 0, 0, 1, 1, 1, 32'h0};
        vt[2]  = '{3'b001, 32'h100, 32'h180, 0, 0, 1, 0, 0, 32'h0};
        vt[3]  = '{3'b100, 32'h200, 32'h300, 1, 0, 0, 0, 1, 32'h300};
        vt[4]  = '{3'b101, 32'h204, 32'h280, 1, 0, 1, 0, 1, 32'h208};
        vt[5]  = '{3'b111, 32'h300, 32'h340, 0, 0, 1, 1, 0, 32'h0};
        vt[6]  = '{3'b010, 32'h340, 32'h400, 1, 1, 1, 1, 0, 32'h0};
        vt[7]  = '{3'b011, 32'h344, 32'h400, 0, 0, 1, 1, 0, 32'h0};
        vt[8]  = '{3'b000, 32'h348, 32'h400, 0, 0, 0, 0, 0, 32'h0};
        vt[9]  = '{3'b001, 32'h34C, 32'h400, 0, 1, 1, 0, 1, 32'h350};
        vt[10] = '{3'b110, 32'h350, 32'h3A0, 1, 0, 0, 1, 1, 32'h3A0};

        reset_n = 1'b0;
        stall   = 1'b0;
        if_pc   = 32'h0;
        set_ex(0, 3'b000, 32'h0, 32'h0, 0, 0, 0);
        model_reset();

        // Reset state
        repeat (2) tick();
        check("rst_redirect", 32'(red_valid), 32'd0);
        check("rst_flush", 32'(flush), 32'd0);
        check("rst_rpc", red_pc, 32'd0);
        chk_stats("rst_stat");
        chk_pred("rst_pred_0", 32'h0);
        chk_pred("rst_pred_100", 32'h100);
        reset_n = 1'b1;
        tick();

        // Table-driven resolution vectors
        for (int i = 0; i < NV; i++) begin
            set_ex(1, vt[i].f3, vt[i].pc, vt[i].tgt,
                   vt[i].less, vt[i].eq, vt[i].pred);
            #1;
            check($sformatf("v%0d_br_un", i), 32'(br_un), 32'(vt[i].e_un));
            model_res(vt[i].f3, vt[i].pc, vt[i].less, vt[i].eq, vt[i].pred);
            sb.push_back('{vt[i].e_red, vt[i].e_pc});
            tick();
            ex_valid = 1'b0;
            e = sb.pop_front();
            check($sformatf("v%0d_redirect", i), 32'(red_valid), 32'(e.v));
            check($sformatf("v%0d_flush", i), 32'(flush), 32'(e.v));
            check($sformatf("v%0d_rpc", i), red_pc, e.pc);
            if (e.v) repeat (DRAIN + 1) tick();
        end
        for (int i = 0; i < NV; i++) begin
            chk_pred($sformatf("v%0d_pred", i), vt[i].pc);
        end

        // Wrong-path EX slots during REDIRECT/DRAIN are ignored
        set_ex(1, 3'b000, 32'h400, 32'h480, 0, 1, 0);
        model_res(3'b000, 32'h400, 0, 1, 0);
        tick();
        check("drn_redirect", 32'(red_valid), 32'd1);
        check("drn_rpc", red_pc, 32'h480);
        set_ex(1, 3'b001, 32'h5F0, 32'h700, 0, 0, 0);
        for (int c = 0; c < DRAIN + 1; c++) begin
            tick();
            check($sformatf("drn_quiet%0d", c), 32'(red_valid), 32'd0);
        end
        set_ex(1, 3'b000, 32'h600, 32'h640, 0, 1, 0);
        model_res(3'b000, 32'h600, 0, 1, 0);
        tick();
        ex_valid = 1'b0;
        check("drn_resume", 32'(red_valid), 32'd1);
        check("drn_resume_rpc", red_pc, 32'h640);
        repeat (DRAIN + 1) tick();
        chk_pred("drn_bht_5f0", 32'h5F0);

        // Saturating counter at pc 0x20, read before same-cycle update
        for (int n = 0; n < 4; n++) begin
            set_ex(1, 3'b001, 32'h20, 32'h60, 0, 0, 1);
            chk_pred($sformatf("sat_up%0d", n), 32'h20);
            model_res(3'b001, 32'h20, 0, 0, 1);
            tick();
            check($sformatf("sat_up%0d_red", n), 32'(red_valid), 32'd0);
        end
        ex_valid = 1'b0;
        chk_pred("sat_hi", 32'h20);
        for (int n = 0; n < 4; n++) begin
            set_ex(1, 3'b001, 32'h20, 32'h60, 0, 1, 0);
            chk_pred($sformatf("sat_dn%0d", n), 32'h20);
            model_res(3'b001, 32'h20, 0, 1, 0);
            tick();
        end
        set_ex(1, 3'b001, 32'h20, 32'h60, 0, 0, 1);
        chk_pred("sat_lo", 32'h20);
        model_res(3'b001, 32'h20, 0, 0, 1);
        tick();
        ex_valid = 1'b0;
        chk_pred("sat_lo_up", 32'h20);

        // Stall in REDIRECT stretches the pulse
        set_ex(1, 3'b000, 32'h700, 32'h7F0, 0, 1, 0);
        model_res(3'b000, 32'h700, 0, 1, 0);
        tick();
        ex_valid = 1'b0;
        stall    = 1'b1;
        for (int c = 0; c < 3; c++) begin
            check($sformatf("stl_pulse%0d", c), 32'(red_valid), 32'd1);
            check($sformatf("stl_rpc%0d", c), red_pc, 32'h7F0);
            tick();
        end
        check("stl_flush", 32'(flush), 32'd1);
        stall = 1'b0;
        tick();
        check("stl_release", 32'(red_valid), 32'd0);
        repeat (DRAIN) tick();

        // Stall in RUN blocks resolution
        stall = 1'b1;
        set_ex(1, 3'b000, 32'h704, 32'h7F0, 0, 1, 0);
        tick();
        check("run_stall_red", 32'(red_valid), 32'd0);
        tick();
        check("run_stall_red2", 32'(red_valid), 32'd0);
        stall    = 1'b0;
        ex_valid = 1'b0;
        chk_pred("run_stall_bht", 32'h704);
        chk_stats("stats");

        // Reset in the middle of DRAIN
        set_ex(1, 3'b000, 32'h20, 32'h90, 0, 1, 0);
        model_res(3'b000, 32'h20, 0, 1, 0);
        tick();
        ex_valid = 1'b0;
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        model_reset();
        check("mid_rst_red", 32'(red_valid), 32'd0);
        chk_pred("mid_rst_pred", 32'h20);
        chk_stats("mid_rst_stat");
        set_ex(1, 3'b101, 32'h80, 32'hC0, 1, 0, 1);
        model_res(3'b101, 32'h80, 1, 0, 1);
        tick();
        ex_valid = 1'b0;
        check("post_rst_red", 32'(red_valid), 32'd1);
        check("post_rst_rpc", red_pc, 32'h84);
        repeat (DRAIN + 1) tick();
        chk_stats("final_stat");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
